// File: rtl/stream_demux_pkg.sv
// Shared definitions for the streaming demultiplexer: default sizes,
// slot state encoding and the select-width helper.
package stream_demux_pkg;

    localparam int DEF_NCH = 4;
    localparam int DEF_DW  = 8;

    // One-entry slot: either holding a beat or not.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    // Select width for n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register for a single demux channel. Loads when the
// top-level routes a beat here and empties when the consumer takes it;
// a load on the draining cycle keeps it full for 1 beat/cycle throughput.
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    slot_state_e   r_state;
    logic          r_valid;
    logic [DW-1:0] r_data;

    // Slot FSM; valid is registered so m_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (i_load) begin
                        r_state <= ST_FULL;
                        r_valid <= 1'b1;
                        r_data  <= i_data;
                    end
                end
                ST_FULL: begin
                    if (i_load) begin
                        // Top only loads a full slot when it is also draining.
                        r_state <= ST_FULL;
                        r_valid <= 1'b1;
                        r_data  <= i_data;
                    end else if (i_ready) begin
                        r_state <= ST_EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/stream_demux.sv
// 1-to-NCH streaming demultiplexer with per-channel one-entry slots,
// back-pressure, out-of-range drop and a saturating drop counter.
// Optional broadcast input enabled by defining STREAM_DEMUX_BROADCAST_EN.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int NCH  = DEF_NCH,
    parameter  int DW   = DEF_DW,
    parameter  int CNTW = 8,
    localparam int SW   = sel_width(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    input  logic [SW-1:0]     s_sel,
`ifdef STREAM_DEMUX_BROADCAST_EN
    input  logic              s_bcast,
`endif
    output logic [NCH-1:0]    m_valid,
    input  logic [NCH-1:0]    m_ready,
    output logic [NCH*DW-1:0] m_data,
    output logic              drop_pulse,
    output logic [CNTW-1:0]   drop_cnt
);

    logic [NCH-1:0]  w_ch_free;
    logic [NCH-1:0]  w_load;
    logic            w_sel_free;
    logic            w_in_range;
    logic            w_bcast;
    logic            w_accept;
    logic            w_drop;
    logic            r_drop_pulse;
    logic [CNTW-1:0] r_drop_cnt;

`ifdef STREAM_DEMUX_BROADCAST_EN
    assign w_bcast = s_bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // A slot can take a beat if it is empty or is being drained this cycle.
    assign w_ch_free  = ~m_valid | m_ready;
    assign w_in_range = (32'(s_sel) < 32'(NCH));

    // Free flag of the selected channel; out-of-range selects are always free.
    always_comb begin
        w_sel_free = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (32'(s_sel) == i) w_sel_free = w_ch_free[i];
        end
    end

    assign s_ready  = w_bcast ? (&w_ch_free) : w_sel_free;
    assign w_accept = s_valid && s_ready;
    assign w_drop   = w_accept && !w_bcast && !w_in_range;

    // Per-channel load strobes: addressed channel, or all on broadcast.
    always_comb begin
        w_load = '0;
        for (int i = 0; i < NCH; i++) begin
            w_load[i] = w_accept && (w_bcast || (w_in_range && (32'(s_sel) == i)));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_slot
            stream_demux_slot #(.DW(DW)) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load[g]),
                .i_data  (s_data),
                .i_ready (m_ready[g]),
                .o_valid (m_valid[g]),
                .o_data  (m_data[g*DW +: DW])
            );
        end
    endgenerate

    // Drop pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_cnt != {CNTW{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign drop_pulse = r_drop_pulse;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux.sv
// Randomized and directed checks of stream_demux (NCH=3 so out-of-range
// selects exist, CNTW=3 so counter saturation is reachable) against a
// per-channel holding model kept in the bench.
module tb_stream_demux;

    localparam int NCH  = 3;
    localparam int DW   = 8;
    localparam int CNTW = 3;
    localparam int SW   = 2;
    localparam int CMAX = (1 << CNTW) - 1;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic [SW-1:0]     s_sel;
    logic              s_bcast;
    logic [NCH-1:0]    m_valid;
    logic [NCH-1:0]    m_ready;
    logic [NCH*DW-1:0] m_data;
    logic              drop_pulse;
    logic [CNTW-1:0]   drop_cnt;

    stream_demux #(.NCH(NCH), .DW(DW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sel      (s_sel),
`ifdef STREAM_DEMUX_BROADCAST_EN
        .s_bcast    (s_bcast),
`endif
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: which channels hold a beat, its payload, drop stats.
    bit       ref_held [NCH];
    bit [7:0] ref_data [NCH];
    bit       ref_pulse;
    int       ref_drops;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mvalid();
        logic [31:0] r = '0;
        for (int i = 0; i < NCH; i++) r[i] = ref_held[i];
        return r;
    endfunction

    function automatic logic [31:0] ref_mdata();
        logic [31:0] r = '0;
        for (int i = 0; i < NCH; i++) r[i*8 +: 8] = ref_data[i];
        return r;
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < NCH; i++) begin
            ref_held[i] = 0;
            ref_data[i] = 0;
        end
        ref_pulse = 0;
        ref_drops = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".m_valid"},    32'(m_valid),    ref_mvalid());
        chk({tag, ".m_data"},     32'(m_data),     ref_mdata());
        chk({tag, ".drop_pulse"}, 32'(drop_pulse), 32'(ref_pulse));
        chk({tag, ".drop_cnt"},   32'(drop_cnt),   32'(ref_drops));
    endtask

    // One clock of traffic, entered and left just after a falling edge.
    task automatic beat(input bit v, input int sel, input bit [7:0] d,
                        input bit [NCH-1:0] mr, input bit bc);
        bit exp_rdy, acc;
        s_valid = v;
        s_sel   = SW'(sel);
        s_data  = d;
        m_ready = mr;
        s_bcast = bc;
        #1;
        if (bc) begin
            exp_rdy = 1;
            for (int i = 0; i < NCH; i++) if (ref_held[i] && !mr[i]) exp_rdy = 0;
        end else if (sel >= NCH) begin
            exp_rdy = 1;
        end else begin
            exp_rdy = !ref_held[sel] || mr[sel];
        end
        chk("s_ready", 32'(s_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        for (int i = 0; i < NCH; i++) begin
            if (ref_held[i] && mr[i]) ref_held[i] = 0;
            if (acc && (bc || sel == i)) begin
                ref_held[i] = 1;
                ref_data[i] = d;
            end
        end
        ref_pulse = acc && !bc && (sel >= NCH);
        if (ref_pulse && ref_drops < CMAX) ref_drops++;
        @(negedge clk);
        chk_outputs("cyc");
    endtask

    initial begin
        bit bc;
        ref_clear();
        rst_n   = 1'b0;
        s_valid = 0; s_sel = 0; s_data = 0; m_ready = 0; s_bcast = 0;

        // Reset held with random inputs.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s_valid = 1'($urandom); s_sel = SW'($urandom);
            s_data = DW'($urandom); m_ready = NCH'($urandom);
            #1;
            chk_outputs("rst");
        end
        @(negedge clk);
        rst_n = 1'b1;
        s_valid = 0;
        #1;
        chk_outputs("rel");

        // Routing, all consumers ready.
        for (int i = 0; i < NCH; i++) beat(1, i, 8'hA0 + 8'(i), '1, 0);
        beat(0, 0, 8'h00, '1, 0);
        chk("route.idle_after", 32'(m_valid), 32'h0);

        // Back-pressure on channel 2 while channel 1 keeps flowing.
        beat(1, 2, 8'h21, 3'b011, 0);
        beat(1, 2, 8'h22, 3'b011, 0);
        chk("bp.held", 32'(m_data[2*8 +: 8]), 32'h21);
        beat(1, 1, 8'h11, 3'b011, 0);
        beat(1, 2, 8'h22, 3'b111, 0);
        chk("bp.second", 32'(m_data[2*8 +: 8]), 32'h22);

        // Out-of-range drops up to saturation.
        for (int k = 0; k < 9; k++) beat(1, 3, 8'(k), '1, 0);
        chk("oor.sat", 32'(drop_cnt), 32'(CMAX));

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
`ifdef STREAM_DEMUX_BROADCAST_EN
            bc = ($urandom_range(3) == 0);
`else
            bc = 0;
`endif
            beat(1'($urandom), int'($urandom_range(3)), 8'($urandom),
                 NCH'($urandom), bc);
        end

        // Fill all slots, then reset asynchronously between edges.
        for (int i = 0; i < NCH; i++) beat(1, i, 8'hC0 + 8'(i), '0, 0);
        chk("mid.full", 32'(m_valid), 32'((1 << NCH) - 1));
        s_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        ref_clear();
        chk("mid.async_valid", 32'(m_valid), 32'h0);
        chk_outputs("mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) beat(0, int'($urandom_range(3)), 8'($urandom), '1, 0);

`ifdef STREAM_DEMUX_BROADCAST_EN
        // Broadcast blocked by a full, stalled slot, then released.
        beat(1, 2, 8'h77, 3'b000, 0);
        beat(1, 0, 8'h5C, 3'b011, 1);
        beat(1, 0, 8'h5C, 3'b111, 1);
        chk("bc.all", 32'(m_data), 32'h5C5C5C);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised 1-to-N streaming demultiplexer with valid/ready handshakes and one registered output slot per channel.
- A beat on the single input stream is routed to the channel given by its select field and held there until that channel's consumer accepts it.
- Successor to the 1-to-4 combinational demux: it is generalised in channel count and data width, and adds back-pressure, out-of-range handling and a drop counter.
- Sits between a single producer and N independent consumers.

Parameters:
- NCH, 4, number of output channels, 2..16.
- DW, 8, data width in bits, >= 1.
- SW, $clog2(NCH), select width; derived, not overridden.
- CNTW, 8, width of the drop counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  DW  input payload
- s_sel  in  SW  destination channel index
- m_valid  out  NCH  per-channel output valid, bit i = channel i
- m_ready  in  NCH  per-channel consumer ready
- m_data  out  NCH*DW  channel i payload at bits [i*DW +: DW]
- drop_pulse  out  1  one-cycle pulse when a beat is dropped
- drop_cnt  out  CNTW  saturating count of dropped beats

Behaviour:
- Reset (asynchronous assert, synchronous release): m_valid=0, m_data=0, drop_pulse=0, drop_cnt=0. s_ready follows the combinational rule below, so it is 1 during reset.
- Each channel has a one-entry slot with two states, EMPTY and FULL.
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on m_ready[i] without load.
  - FULL -> FULL on m_ready[i] with simultaneous load; this gives back-to-back throughput of 1 beat/cycle per channel.
- s_ready is combinational: s_ready = (s_sel >= NCH) || !m_valid[s_sel] || m_ready[s_sel].
  - s_ready depends only on the selected channel; other channels never stall the input.
- Accept = s_valid && s_ready. On accept with in-range s_sel, slot s_sel loads s_data and m_valid[s_sel]=1 on the next edge. Latency is 1 cycle.
- m_data of a channel holds its value while m_valid is low; it is cleared only by reset.
- Out-of-range s_sel (possible only when NCH is not a power of 2):
  - The beat is always accepted and discarded; no m_valid bit changes.
  - drop_pulse=1 for exactly the next cycle.
  - drop_cnt increments and saturates at all-ones, never wrapping.
- Simultaneous drain of one channel and load of another: both take effect in the same cycle.
- m_valid is never dependent on m_ready in the same cycle, so there is no combinational path m_ready -> m_valid.
- Asserting rst_n low mid-transfer discards all held beats immediately. No partial beat survives.
- While s_valid is low, s_data and s_sel are ignored.

Optional Feature:
- Macro: STREAM_DEMUX_BROADCAST_EN.
- When defined:
  - Extra input port s_bcast (1 bit).
  - A beat with s_bcast=1 loads all NCH slots; s_sel is ignored and the beat is never dropped.
  - s_ready for a broadcast beat = AND over i of (!m_valid[i] || m_ready[i]).
  - Each channel then drains independently.
- When undefined: no s_bcast port; behaviour is exactly as above.

Decomposition:
- Shared package stream_demux_pkg holds:
  - the select-width function (clog2 helper);
  - the slot state encoding constants ST_EMPTY/ST_FULL;
  - the default DW/NCH constants.
- Natural sub-module stream_demux_slot: one-entry register with load, data_in, ready, valid and data_out, instantiated NCH times in a generate loop.
- The top level holds the s_ready mux, the out-of-range detect and the drop counter.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> m_valid=0, drop_cnt=0, drop_pulse=0; release -> m_valid stays 0 until first accept.
- Routing: NCH=4, all m_ready=1, send sel=0,1,2,3 with data 0xA0..0xA3 -> each channel i shows 0xA0+i one cycle later, one beat each, m_valid pulses 1 cycle.
- Back-pressure: m_ready[2]=0, send two beats to sel=2 -> first held in slot, s_ready=0 on second; raise m_ready[2] -> second accepted the same cycle and the first is consumed; meanwhile beats to sel=1 flow unstalled.
- Out-of-range: NCH=3, send sel=3 five times -> s_ready=1, no m_valid, five drop_pulse cycles, drop_cnt=5; with CNTW=2 -> drop_cnt saturates at 3.
- Mid-operation reset: fill all slots with m_ready=0, pulse rst_n low between edges -> m_valid clears immediately (async) and no beat appears after release.
- Broadcast (macro defined): s_bcast=1, data 0x5C, m_ready=4'b1011 with slot 2 full -> s_ready=0; release m_ready[2] -> all four channels show 0x5C next cycle.
